// File: rtl/wsched_pkg.sv
// rtl/wsched_pkg.sv - shared state type, defaults and width helpers for window_scheduler
package wsched_pkg;

  typedef enum logic [1:0] {IDLE, PRIME, RUN, FLUSH} wsched_state_e;

  localparam int DEF_PIC_WIDTH  = 320;
  localparam int DEF_PIC_HEIGHT = 240;
  localparam int DEF_ENG_LAT    = 2;

  // Counter width for a range of n values; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_COL_W = cnt_w(DEF_PIC_WIDTH);
  localparam int DEF_ROW_W = cnt_w(DEF_PIC_HEIGHT);

endpackage

// File: rtl/wsched_delay.sv
// rtl/wsched_delay.sv - DEPTH-stage sideband shift register, async reset plus synchronous clear
module wsched_delay #(
  parameter int DEPTH = 2,
  parameter int W     = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] sr [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else begin
      sr[0] <= din;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/window_scheduler.sv
// rtl/window_scheduler.sv - frame/line sequencer for the 3x3 window engine; WSCHED_BORDER_EN also emits border pixels
module window_scheduler
  import wsched_pkg::*;
#(
  parameter int PIC_WIDTH  = DEF_PIC_WIDTH,
  parameter int PIC_HEIGHT = DEF_PIC_HEIGHT,
  parameter int ENG_LAT    = DEF_ENG_LAT,
  localparam int CW        = cnt_w(PIC_WIDTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic          s_sof,
  input  logic          s_eol,
  output logic          lb_wr_en,
  output logic [CW-1:0] lb_addr,
  output logic          lb_rot,
  output logic          eng_valid,
  output logic          eng_border,
  output logic          m_valid,
  output logic          m_sof,
  output logic          m_eol,
  output logic          m_border,
  output logic          frame_done,
  output logic          err_len
);

  localparam int RW = cnt_w(PIC_HEIGHT);
  localparam int FW = cnt_w(ENG_LAT);
  localparam logic [CW-1:0] COL_LAST    = CW'(PIC_WIDTH - 1);
  localparam logic [CW-1:0] COL_BORDER  = CW'(2);
  localparam logic [RW-1:0] ROW_LAST    = RW'(PIC_HEIGHT - 1);
  localparam logic [RW-1:0] ROW_RUN     = RW'(2);
  localparam logic [RW-1:0] ROW_PRIME_1 = RW'(1);
  localparam logic [FW-1:0] FLUSH_LAST  = FW'(ENG_LAT - 1);
`ifdef WSCHED_BORDER_EN
  localparam logic [CW-1:0] SOF_COL = '0;
  localparam int DW = 4;
`else
  localparam logic [CW-1:0] SOF_COL = CW'(2);
  localparam int DW = 3;
`endif

  wsched_state_e state, state_nx;
  logic [CW-1:0] col, eff_col;
  logic [RW-1:0] row, eff_row;
  logic [FW-1:0] flush_cnt;
  logic          accept, take, restart, at_last_col, line_end, frame_end, len_err;
  logic          sof_tag, eol_tag;
  logic [DW-1:0] dly_in, dly_out;

  assign s_ready = (state != FLUSH);
  assign accept  = s_valid && s_ready;
  // Pixels seen in IDLE are only kept once a start-of-frame arrives.
  assign take    = accept && (s_sof || state != IDLE);
  assign restart = accept && s_sof && (state == PRIME || state == RUN);

  // An accepted sof always lands at row0/col0, whatever the counters held.
  assign eff_col     = s_sof ? '0 : col;
  assign eff_row     = s_sof ? '0 : row;
  assign at_last_col = (eff_col == COL_LAST);
  assign line_end    = s_eol || at_last_col;
  assign frame_end   = line_end && (eff_row == ROW_LAST);
  assign len_err     = (s_eol != at_last_col);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (state == FLUSH) begin
      if (flush_cnt == FLUSH_LAST) state_nx = IDLE;
    end else if (take) begin
      if (frame_end)
        state_nx = FLUSH;
      else if (eff_row >= ROW_RUN || (line_end && eff_row == ROW_PRIME_1))
        state_nx = RUN;
      else
        state_nx = PRIME;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col        <= '0;
      row        <= '0;
      flush_cnt  <= '0;
      lb_wr_en   <= 1'b0;
      lb_addr    <= '0;
      lb_rot     <= 1'b0;
      eng_valid  <= 1'b0;
      eng_border <= 1'b0;
      sof_tag    <= 1'b0;
      eol_tag    <= 1'b0;
      err_len    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      lb_wr_en   <= take;
      lb_rot     <= take && line_end;
      eng_valid  <= take && (eff_row >= ROW_RUN);
      eng_border <= take && (eff_row >= ROW_RUN) && (eff_col < COL_BORDER);
      sof_tag    <= take && (eff_row == ROW_RUN) && (eff_col == SOF_COL);
      eol_tag    <= take && (eff_row >= ROW_RUN) && at_last_col;
      err_len    <= restart || (take && len_err);
      frame_done <= (state == FLUSH) && (flush_cnt == FLUSH_LAST);
      flush_cnt  <= (state == FLUSH) ? flush_cnt + 1'b1 : '0;
      if (take) begin
        lb_addr <= eff_col;
        // A missing eol at the last column still wraps, so the next pixel resyncs to col0.
        if (line_end) begin
          col <= '0;
          row <= frame_end ? '0 : eff_row + 1'b1;
        end else begin
          col <= eff_col + 1'b1;
          row <= eff_row;
        end
      end
    end
  end

`ifdef WSCHED_BORDER_EN
  assign dly_in = {eng_border, eng_valid, sof_tag, eol_tag};
  assign {m_border, m_valid, m_sof, m_eol} = dly_out;
`else
  assign dly_in = {eng_valid && !eng_border, sof_tag, eol_tag};
  assign {m_valid, m_sof, m_eol} = dly_out;
  assign m_border = 1'b0;
`endif

  wsched_delay #(
    .DEPTH (ENG_LAT),
    .W     (DW)
  ) u_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (restart),
    .din   (dly_in),
    .dout  (dly_out)
  );

endmodule
